// File: rtl/crack_job_issuer.sv
// rtl/crack_job_issuer.sv - hands 4-char password jobs to a cracker and reports the outcome
// Optional RUN-cycle limit: define CRACK_TIMEOUT_EN.
module crack_job_issuer #(
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_password,
  output logic [32:0] cracker_password,
  output logic        cracker_rst,
  input  logic        cracker_found,
  input  logic        cracker_done,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_found,
  output logic        result_invalid,
  output logic        result_timeout,
  output logic [31:0] result_cycles
);

  localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RW-1:0] RST_LAST = RW'(RST_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    RESTART = 3'd2,
    RUN     = 3'd3,
    REPORT  = 3'd4
  } state_t;

  state_t        state, state_next;
  logic [31:0]   pw;
  logic [31:0]   cyc;
  logic [31:0]   cyc_inc;
  logic [RW-1:0] rst_cnt;
  logic          res_found;
  logic          res_invalid;
  logic          chars_ok;
  logic          hit_limit;

  function automatic logic char_ok(input logic [7:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h5A));
  endfunction

  assign chars_ok = char_ok(pw[31:24]) && char_ok(pw[23:16]) &&
                    char_ok(pw[15:8])  && char_ok(pw[7:0]);

  // Counter sticks at all-ones rather than wrapping back to a small value.
  assign cyc_inc = (cyc == 32'hFFFF_FFFF) ? cyc : cyc + 32'd1;

`ifdef CRACK_TIMEOUT_EN
  logic res_timeout;
  assign hit_limit      = (cyc_inc >= 32'(TIMEOUT));
  assign result_timeout = res_timeout;
`else
  assign hit_limit      = 1'b0;
  assign result_timeout = 1'b0;
`endif

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (job_valid) state_next = CHECK;
      CHECK:   state_next = chars_ok ? RESTART : REPORT;
      RESTART: if (rst_cnt == RST_LAST) state_next = RUN;
      RUN:     if (cracker_found || cracker_done || hit_limit) state_next = REPORT;
      REPORT:  if (result_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pw          <= '0;
      cyc         <= '0;
      rst_cnt     <= '0;
      res_found   <= 1'b0;
      res_invalid <= 1'b0;
`ifdef CRACK_TIMEOUT_EN
      res_timeout <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (job_valid) begin
            pw          <= job_password;
            cyc         <= '0;
            res_found   <= 1'b0;
            res_invalid <= 1'b0;
`ifdef CRACK_TIMEOUT_EN
            res_timeout <= 1'b0;
`endif
          end
        end
        CHECK: begin
          rst_cnt <= '0;
          if (!chars_ok) res_invalid <= 1'b1;
        end
        RESTART: begin
          rst_cnt <= rst_cnt + 1'b1;
          cyc     <= '0;
        end
        RUN: begin
          cyc <= cyc_inc;
          if (cracker_found) res_found <= 1'b1;
`ifdef CRACK_TIMEOUT_EN
          if (!cracker_found && !cracker_done && hit_limit) res_timeout <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

  assign job_ready        = (state == IDLE);
  assign cracker_rst      = rst || (state == RESTART);
  assign cracker_password = {1'b0, pw};
  assign result_valid     = (state == REPORT);
  assign result_found     = res_found;
  assign result_invalid   = res_invalid;
  assign result_cycles    = cyc;

endmodule

// File: tb/tb_crack_job_issuer.sv
// tb/tb_crack_job_issuer.sv - directed self-checking bench for crack_job_issuer
module tb_crack_job_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [31:0] job_password;
  logic [32:0] cracker_password;
  logic        cracker_rst;
  logic        cracker_found;
  logic        cracker_done;
  logic        result_valid;
  logic        result_ready;
  logic        result_found;
  logic        result_invalid;
  logic        result_timeout;
  logic [31:0] result_cycles;

  int n_checks = 0;
  int n_fails  = 0;

  crack_job_issuer #(.RST_CYCLES(2), .TIMEOUT(50)) dut (
    .clk              (clk),
    .rst              (rst),
    .job_valid        (job_valid),
    .job_ready        (job_ready),
    .job_password     (job_password),
    .cracker_password (cracker_password),
    .cracker_rst      (cracker_rst),
    .cracker_found    (cracker_found),
    .cracker_done     (cracker_done),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_found     (result_found),
    .result_invalid   (result_invalid),
    .result_timeout   (result_timeout),
    .result_cycles    (result_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hands a job over and walks it through CHECK and RESTART; returns in RUN cycle 1.
  task automatic start_job(input logic [31:0] pw);
    job_password = pw;
    job_valid    = 1'b1;
    check("accept_ready", job_ready, 1'b1);
    tick();
    job_valid = 1'b0;
    check("check_busy", job_ready, 1'b0);
    check("check_no_rst", cracker_rst, 1'b0);
    tick();
    check("restart1_rst", cracker_rst, 1'b1);
    tick();
    check("restart2_rst", cracker_rst, 1'b1);
    tick();
    check("run1_rst_low", cracker_rst, 1'b0);
    check("run1_no_result", result_valid, 1'b0);
  endtask

  task automatic take_result();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("back_idle_ready", job_ready, 1'b1);
    check("back_idle_nores", result_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_password = '0;
    cracker_found = 1'b0; cracker_done = 1'b0; result_ready = 1'b0;
    #1;
    check("rst_cracker_rst", cracker_rst, 1'b1);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_job_ready", job_ready, 1'b1);
    check("rst_cracker_rst_low", cracker_rst, 1'b0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result_cycles", result_cycles, 32'd0);
    check("rst_password", cracker_password, 33'd0);
    check("rst_timeout", result_timeout, 1'b0);

    // "0001", found on RUN cycle 2; result_ready high during RUN must be ignored
    start_job(32'h30303031);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    cracker_found = 1'b1;
    check("j1_still_run", result_valid, 1'b0);
    tick();
    cracker_found = 1'b0;
    check("j1_valid", result_valid, 1'b1);
    check("j1_found", result_found, 1'b1);
    check("j1_invalid", result_invalid, 1'b0);
    check("j1_cycles", result_cycles, 32'd2);
    check("j1_password", cracker_password, {1'b0, 32'h30303031});
    take_result();
    check("j1_pw_held", cracker_password, {1'b0, 32'h30303031});

    // "ab#1" is rejected without restarting the cracker
    job_password = 32'h61622331;
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
    check("j2_check_no_rst", cracker_rst, 1'b0);
    tick();
    check("j2_valid", result_valid, 1'b1);
    check("j2_invalid", result_invalid, 1'b1);
    check("j2_found", result_found, 1'b0);
    check("j2_cycles", result_cycles, 32'd0);
    check("j2_no_rst", cracker_rst, 1'b0);
    take_result();

    // found and done together on RUN cycle 10
    start_job(32'h4B39415A);
    for (int i = 0; i < 9; i++) tick();
    cracker_found = 1'b1;
    cracker_done  = 1'b1;
    tick();
    cracker_found = 1'b0;
    cracker_done  = 1'b0;
    check("j3_valid", result_valid, 1'b1);
    check("j3_found", result_found, 1'b1);
    check("j3_cycles", result_cycles, 32'd10);
    take_result();

    // done alone on RUN cycle 3, consumer stalls 5 cycles
    start_job(32'h41395A30);
    tick(); tick();
    cracker_done = 1'b1;
    tick();
    cracker_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("j4_hold_valid", result_valid, 1'b1);
      check("j4_hold_found", result_found, 1'b0);
      check("j4_hold_cycles", result_cycles, 32'd3);
      check("j4_hold_ready", job_ready, 1'b0);
      tick();
    end
    take_result();

    // reset on RUN cycle 100 discards the job
    start_job(32'h39393939);
    for (int i = 0; i < 99; i++) tick();
    check("j5_still_run", result_valid, 1'b0);
    rst = 1'b1;
    #1;
    check("j5_rst_cracker_rst", cracker_rst, 1'b1);
    tick();
    rst = 1'b0;
    #1;
    check("j5_idle_ready", job_ready, 1'b1);
    check("j5_rst_low", cracker_rst, 1'b0);
    check("j5_valid", result_valid, 1'b0);
    check("j5_cycles", result_cycles, 32'd0);
    check("j5_password", cracker_password, 33'd0);
    check("j5_found", result_found, 1'b0);

    // "ZZZZ" after the reset completes normally, found on RUN cycle 5
    start_job(32'h5A5A5A5A);
    for (int i = 0; i < 4; i++) tick();
    cracker_found = 1'b1;
    tick();
    cracker_found = 1'b0;
    check("j6_valid", result_valid, 1'b1);
    check("j6_found", result_found, 1'b1);
    check("j6_cycles", result_cycles, 32'd5);
    check("j6_password", cracker_password, {1'b0, 32'h5A5A5A5A});
    take_result();

    // silent cracker: times out at 50 only when the limit is compiled in
    start_job(32'h31323334);
`ifdef CRACK_TIMEOUT_EN
    for (int i = 0; i < 49; i++) tick();
    check("j7_pre_limit", result_valid, 1'b0);
    tick();
    check("j7_valid", result_valid, 1'b1);
    check("j7_timeout", result_timeout, 1'b1);
    check("j7_found", result_found, 1'b0);
    check("j7_cycles", result_cycles, 32'd50);
`else
    for (int i = 0; i < 60; i++) tick();
    check("j7_no_limit", result_valid, 1'b0);
    cracker_done = 1'b1;
    tick();
    cracker_done = 1'b0;
    check("j7_valid", result_valid, 1'b1);
    check("j7_timeout", result_timeout, 1'b0);
    check("j7_found", result_found, 1'b0);
    check("j7_cycles", result_cycles, 32'd61);
`endif
    take_result();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
